// File: rtl/usb_consts_pkg.sv
// Shared constants for the full-speed OUT buffer controller: PIDs, FSM
// encodings and descriptor geometry helpers.
package usb_consts_pkg;

  localparam logic [3:0] PidOut   = 4'b0001;
  localparam logic [3:0] PidIn    = 4'b1001;
  localparam logic [3:0] PidSetup = 4'b1101;
  localparam logic [3:0] PidData0 = 4'b0011;
  localparam logic [3:0] PidData1 = 4'b1011;
  localparam logic [3:0] PidAck   = 4'b0010;
  localparam logic [3:0] PidNak   = 4'b1010;

  localparam int EpW = 4;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRecv = 2'd1;
  localparam logic [1:0] StDrop = 2'd2;

  // Descriptor layout {setup, ep, size[pkt_w:0], buf_id}; size needs one
  // extra bit so a full MaxPktSize payload is representable.
  function automatic int desc_width(input int pkt_w, input int buf_w);
    return 1 + EpW + (pkt_w + 1) + buf_w;
  endfunction

  typedef struct packed {
    logic       setup;
    logic [3:0] ep;
    logic [5:0] size;
    logic [1:0] buf_id;
  } out_desc_t;

endpackage

// File: rtl/usb_sync_fifo.sv
// Small synchronous FIFO with first-word head output; push when full and
// pop when empty are ignored, simultaneous push/pop are both honoured.
module usb_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_48mhz_i,
  input  logic             rst_ni,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
    return (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_48mhz_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/usb_out_buf_ctrl.sv
// OUT buffer controller: claims a free packet buffer per transfer, streams
// bytes into packet SRAM and commits a descriptor to the rx FIFO on ACK.
module usb_out_buf_ctrl
  import usb_consts_pkg::*;
#(
  parameter logic [4:0] NumOutEps  = 5'd1,
  parameter int         MaxPktSize = 32,
  parameter int         NumBufs    = 4,
  parameter int         FifoDepth  = 4,
  localparam int        BufW  = $clog2(NumBufs),
  localparam int        PktW  = $clog2(MaxPktSize),
  localparam int        DescW = desc_width(PktW, BufW)
) (
  input  logic                 clk_48mhz_i,
  input  logic                 rst_ni,
  input  logic                 link_reset_i,
  input  logic [NumOutEps-1:0] ep_enable_i,
  input  logic [3:0]           out_ep_current_i,
  input  logic                 out_ep_newpkt_i,
  input  logic                 out_ep_data_put_i,
  input  logic [7:0]           out_ep_data_i,
  input  logic                 out_ep_acked_i,
  input  logic                 out_ep_rollback_i,
  input  logic [NumOutEps-1:0] out_ep_setup_i,
  output logic [NumOutEps-1:0] out_ep_full_o,
  input  logic                 av_wvalid_i,
  output logic                 av_wready_o,
  input  logic [BufW-1:0]      av_wdata_i,
  output logic                 rx_rvalid_o,
  input  logic                 rx_rready_i,
  output logic [DescW-1:0]     rx_rdata_o,
  output logic                 mem_we_o,
  output logic [BufW+PktW-1:0] mem_addr_o,
  output logic [7:0]           mem_wdata_o,
  output logic                 drop_o
);

  localparam logic [PktW:0] MaxCnt = (PktW+1)'(MaxPktSize);

  logic                 av_pop, av_full, av_empty;
  logic [BufW-1:0]      av_head;
  logic                 rx_push, rx_full, rx_empty;
  logic [DescW-1:0]     rx_wdata;

  logic [1:0]           state_q;
  logic [3:0]           cur_ep_q;
  logic                 setup_q, ovf_q, accepted_q;
  logic [BufW-1:0]      buf_id_q;
  logic [PktW:0]        cnt_q;
  logic                 mem_we_q, drop_q;
  logic [BufW+PktW-1:0] mem_addr_q;
  logic [7:0]           mem_wdata_q;

  logic [NumOutEps-1:0] accept_vec;
  logic [15:0]          accept_ext, setup_ext;

  usb_sync_fifo #(.WIDTH(BufW), .DEPTH(FifoDepth)) u_avail_fifo (
    .clk_48mhz_i (clk_48mhz_i),
    .rst_ni      (rst_ni),
    .push        (av_wvalid_i),
    .wdata       (av_wdata_i),
    .pop         (av_pop),
    .head        (av_head),
    .full        (av_full),
    .empty       (av_empty)
  );

  usb_sync_fifo #(.WIDTH(DescW), .DEPTH(FifoDepth)) u_rx_fifo (
    .clk_48mhz_i (clk_48mhz_i),
    .rst_ni      (rst_ni),
    .push        (rx_push),
    .wdata       (rx_wdata),
    .pop         (rx_rready_i),
    .head        (rx_rdata_o),
    .full        (rx_full),
    .empty       (rx_empty)
  );

  // Zero-extended to 16 so any 4-bit endpoint number indexes safely; EPs
  // beyond NumOutEps simply never accept.
  assign accept_vec = (ep_enable_i | out_ep_setup_i) & {NumOutEps{~av_empty & ~rx_full}};
  assign accept_ext = 16'(accept_vec);
  assign setup_ext  = 16'(out_ep_setup_i);

  assign av_wready_o = ~av_full;
  assign rx_rvalid_o = ~rx_empty;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign drop_o      = drop_q;

  assign rx_wdata = {setup_q, cur_ep_q, cnt_q, buf_id_q};
  assign rx_push  = (state_q == StRecv) & out_ep_acked_i & ~out_ep_rollback_i & ~ovf_q &
                    ~out_ep_newpkt_i & ~link_reset_i;
  assign av_pop   = rx_push;

  always_comb begin
    for (int i = 0; i < NumOutEps; i++) begin
      out_ep_full_o[i] = ~accept_vec[i];
      if ((state_q != StIdle) && (cur_ep_q == 4'(i))) out_ep_full_o[i] = ~accepted_q;
    end
  end

  // newpkt wins over everything but link reset, so a restarted transfer
  // abandons the old one without committing it.
  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      cur_ep_q    <= '0;
      setup_q     <= 1'b0;
      buf_id_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      accepted_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      drop_q      <= 1'b0;
    end else begin
      mem_we_q <= 1'b0;
      drop_q   <= 1'b0;
      if (link_reset_i) begin
        state_q <= StIdle;
      end else if (out_ep_newpkt_i) begin
        cur_ep_q   <= out_ep_current_i;
        setup_q    <= setup_ext[out_ep_current_i];
        buf_id_q   <= av_head;
        cnt_q      <= '0;
        ovf_q      <= 1'b0;
        accepted_q <= accept_ext[out_ep_current_i];
        state_q    <= accept_ext[out_ep_current_i] ? StRecv : StDrop;
      end else begin
        case (state_q)
          StRecv: begin
            if (out_ep_rollback_i) begin
              state_q <= StIdle;
            end else if (out_ep_acked_i) begin
              drop_q  <= ovf_q;
              state_q <= StIdle;
            end else if (out_ep_data_put_i) begin
              if (cnt_q < MaxCnt) begin
                mem_we_q    <= 1'b1;
                mem_addr_q  <= {buf_id_q, cnt_q[PktW-1:0]};
                mem_wdata_q <= out_ep_data_i;
                cnt_q       <= cnt_q + 1'b1;
              end else begin
                ovf_q <= 1'b1;
              end
            end
          end
          StDrop: begin
            if (out_ep_rollback_i) begin
              state_q <= StIdle;
            end else if (out_ep_acked_i) begin
              drop_q  <= 1'b1;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule
